router_pkt_reader: RTL and testbench
====================================

Name: router_pkt_reader

Overview:
Destination-side read controller for one router output port. It watches the port's vld_out and drains one packet at a time from the output FIFO by driving read_enb. It parses the header, streams payload bytes to a downstream sink with backpressure, checks the address field and the parity byte, and reports per-packet status. One instance sits behind each of the three output FIFOs. Its read_enb feeds the read_enb_x input of the synchronizer, so prompt reading keeps the 30-cycle soft-reset timeout from firing.

Parameters:
PORT_ID, 2'd0, expected address field (header[1:0]) for this port
CNT_W, 16, width of the wrapping good-packet counter

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
vld_out  input  1  FIFO non-empty (~empty)
data_out  input  8  FIFO read data; valid the cycle after read_enb is high
soft_reset  input  1  synchronizer timeout pulse for this port; FIFO is flushed
sink_ready  input  1  downstream can accept new reads
read_enb  output  1  FIFO read strobe (combinational from state/counters/inputs)
byte_out  output  8  payload byte to sink
byte_valid  output  1  byte_out valid, payload bytes only
byte_last  output  1  with byte_valid, marks final payload byte
pkt_done  output  1  one-cycle pulse, packet complete
pkt_len  output  6  payload length of the last completed packet
parity_err  output  1  qualified by pkt_done; computed parity != received parity
addr_err  output  1  qualified by pkt_done; header[1:0] != PORT_ID
pkt_abort  output  1  one-cycle pulse, packet abandoned on soft_reset
busy  output  1  state != IDLE
pkt_count  output  CNT_W  packets completed with no error; wraps modulo 2^CNT_W

Behaviour:
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then a parity byte. The parity byte equals the XOR of the header and all payload bytes.
- Reset: all registered outputs are 0, state is IDLE, and the counters and parity accumulator are 0. read_enb is 0 during reset.
- States: IDLE, HDR_CAP, BODY, DONE.
- IDLE: read_enb = vld_out & sink_ready. When it is 1, go to HDR_CAP.
- HDR_CAP: read_enb = 0.
  - Latch data_out as the header.
  - Load the parity accumulator with the header value.
  - Set reads_left = len+1.
  - Go to BODY.
- BODY: read_enb = vld_out & sink_ready & (reads_left != 0). Each read decrements reads_left.
  - The cycle after each read is the capture cycle.
  - Payload captures: byte_out = data_out and byte_valid = 1; the byte is XORed into the accumulator.
  - byte_last accompanies the len-th payload byte.
  - Parity capture: compare against the accumulator and go to DONE.
- DONE: read_enb = 0.
  - pkt_done = 1; pkt_len, parity_err and addr_err are updated.
  - pkt_count increments if both errors are 0.
  - Next state is IDLE.
- Timing: minimum packet time is len+5 cycles from the header read to the first IDLE cycle.
- Backpressure: sink_ready low blocks new reads only. A byte already in flight is still presented the next cycle, so the sink must absorb one byte after deasserting ready.
- vld_out low mid-packet (writer slower than reader): stall in BODY with no read. This is not an error.
- len = 0: no payload, no byte_valid. The parity byte is read and checked normally.
- addr_err: does not suppress reading. The packet is fully drained so the FIFO stays framed.
- soft_reset high in any non-IDLE state:
  - Next cycle is IDLE with pkt_abort pulsed.
  - No pkt_done; pkt_count is unchanged.
  - An in-flight capture is discarded.
  - read_enb = 0 in the soft_reset cycle.
- soft_reset in IDLE: ignored, no pulse.
- Asynchronous resetn mid-packet: immediate return to reset values with no pulses. Reframing relies on the FIFO also being reset.
- The read for the next header is never issued in DONE, so back-to-back packets have a one-cycle gap.

Decomposition:
- Shared package router_pkg holds:
  - the state enum;
  - header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0);
  - LEN_W=6, DATA_W=8;
  - SOFT_RESET_TIMEOUT=30, for bench checks.
- One sub-module, router_pkt_parity: an XOR accumulator with load, update and compare, reused by the transmitter-side parity generator.

Test Plan:
1. PORT_ID=0; FIFO holds 0C,11,22,33,0C; sink_ready=1; vld_out rises at cycle 0.
   - read_enb high in cycles 0 and 2-5.
   - byte_valid in cycles 3-5 with 11,22,33; byte_last in cycle 5.
   - pkt_done in cycle 7 with pkt_len=3 and both errors 0; pkt_count=1.
2. Same packet with parity byte 0D -> pkt_done with parity_err=1; pkt_count unchanged; next packet is read correctly.
3. Header 0D (addr 1) at PORT_ID=0 -> all 3 payload bytes delivered, then pkt_done with addr_err=1.
4. Header 00 then parity 00 -> no byte_valid; pkt_done with pkt_len=0 and no errors, within 5 cycles of the header read.
5. sink_ready dropped for 10 cycles after the first payload read -> exactly one more byte is delivered, then no read_enb for 10 cycles; resume gives the correct bytes and parity. Repeat with vld_out gaps.
6. Hold sink_ready low mid-packet and pulse soft_reset -> pkt_abort the next cycle, busy=0, no pkt_done. Then load a fresh packet 08,AA,A2 -> clean pkt_done with pkt_len=2.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port read path: reader state,
// header field layout and widths.
package router_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR_CAP = 2'd1,
      BODY    = 2'd2,
      DONE    = 2'd3
   } rd_state_e;

   localparam int DATA_W             = 8;
   localparam int LEN_W              = 6;
   localparam int LEN_MSB            = 7;
   localparam int LEN_LSB            = 2;
   localparam int ADDR_MSB           = 1;
   localparam int ADDR_LSB           = 0;
   localparam int SOFT_RESET_TIMEOUT = 30;

   function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
      return hdr[LEN_MSB:LEN_LSB];
   endfunction

endpackage

// File: rtl/router_pkt_parity.sv
// XOR parity accumulator: load a seed, fold in bytes, compare against a
// received parity value.
module router_pkt_parity
   import router_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         upd_i,
   input  logic [W-1:0] upd_val_i,
   input  logic [W-1:0] cmp_val_i,
   output logic         mismatch_o
);

   logic [W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (load_i)
         acc_d = load_val_i;
      else if (upd_i)
         acc_d = acc_q ^ upd_val_i;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) acc_q <= '0;
      else         acc_q <= acc_d;
   end

   assign mismatch_o = (acc_q != cmp_val_i);

endmodule

// File: rtl/router_pkt_reader.sv
// Drains one packet at a time from a router output FIFO, streams the payload
// to a sink and reports length, address and parity status per packet.
module router_pkt_reader
   import router_pkg::*;
#(
   parameter logic [1:0] PORT_ID = 2'd0,
   parameter int         CNT_W   = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              vld_out,
   input  logic [DATA_W-1:0] data_out,
   input  logic              soft_reset,
   input  logic              sink_ready,
   output logic              read_enb,
   output logic [DATA_W-1:0] byte_out,
   output logic              byte_valid,
   output logic              byte_last,
   output logic              pkt_done,
   output logic [LEN_W-1:0]  pkt_len,
   output logic              parity_err,
   output logic              addr_err,
   output logic              pkt_abort,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_count
);

   rd_state_e         state_q, state_d;
   logic [DATA_W-1:0] hdr_q, hdr_d;
   logic [LEN_W:0]    reads_left_q, reads_left_d;
   logic              cap_q, cap_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              perr_q, perr_d;
   logic              aerr_q, aerr_d;
   logic              abort_q, abort_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic par_load, par_upd, par_mis;
   logic cap_pay, abort_now;

   assign abort_now = soft_reset & (state_q != IDLE);

   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      reads_left_d = reads_left_q;
      len_d        = len_q;
      perr_d       = perr_q;
      aerr_d       = aerr_q;
      cnt_d        = cnt_q;
      read_enb     = 1'b0;
      par_load     = 1'b0;
      par_upd      = 1'b0;
      cap_pay      = 1'b0;
      unique case (state_q)
         IDLE: begin
            read_enb = vld_out & sink_ready;
            if (read_enb) state_d = HDR_CAP;
         end
         HDR_CAP: begin
            hdr_d        = data_out;
            par_load     = 1'b1;
            reads_left_d = {1'b0, hdr_len(data_out)} + (LEN_W+1)'(1);
            state_d      = BODY;
         end
         BODY: begin
            read_enb = vld_out & sink_ready & (reads_left_q != '0);
            if (read_enb) reads_left_d = reads_left_q - (LEN_W+1)'(1);
            // reads_left already reflects the read being captured: 0 means parity byte
            if (cap_q) begin
               if (reads_left_q == '0) begin
                  perr_d  = par_mis;
                  aerr_d  = (hdr_q[ADDR_MSB:ADDR_LSB] != PORT_ID);
                  len_d   = hdr_len(hdr_q);
                  state_d = DONE;
               end else begin
                  cap_pay = 1'b1;
                  par_upd = 1'b1;
               end
            end
         end
         DONE: begin
            if (!perr_q && !aerr_q) cnt_d = cnt_q + CNT_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort_now) begin
         state_d      = IDLE;
         read_enb     = 1'b0;
         par_load     = 1'b0;
         par_upd      = 1'b0;
         cap_pay      = 1'b0;
         hdr_d        = hdr_q;
         reads_left_d = reads_left_q;
         len_d        = len_q;
         perr_d       = perr_q;
         aerr_d       = aerr_q;
         cnt_d        = cnt_q;
      end
      cap_d   = (state_q == BODY) & read_enb;
      abort_d = abort_now;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         hdr_q        <= '0;
         reads_left_q <= '0;
         cap_q        <= 1'b0;
         len_q        <= '0;
         perr_q       <= 1'b0;
         aerr_q       <= 1'b0;
         abort_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         reads_left_q <= reads_left_d;
         cap_q        <= cap_d;
         len_q        <= len_d;
         perr_q       <= perr_d;
         aerr_q       <= aerr_d;
         abort_q      <= abort_d;
         cnt_q        <= cnt_d;
      end
   end

   router_pkt_parity #(.W(DATA_W)) u_parity (
      .clock      (clock),
      .resetn     (resetn),
      .load_i     (par_load),
      .load_val_i (data_out),
      .upd_i      (par_upd),
      .upd_val_i  (data_out),
      .cmp_val_i  (data_out),
      .mismatch_o (par_mis)
   );

   assign byte_out   = data_out;
   assign byte_valid = cap_pay;
   assign byte_last  = cap_pay & (reads_left_q == (LEN_W+1)'(1));
   assign pkt_done   = (state_q == DONE) & ~soft_reset;
   assign pkt_len    = len_q;
   assign parity_err = perr_q;
   assign addr_err   = aerr_q;
   assign pkt_abort  = abort_q;
   assign busy       = (state_q != IDLE);
   assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader with a small FIFO model feeding data_out.
module tb_router_pkt_reader;
   import router_pkg::*;

   logic        clock = 1'b0;
   logic        resetn, soft_reset, sink_ready;
   logic        vld_out;
   logic [7:0]  data_out;
   logic        read_enb, byte_valid, byte_last, pkt_done, parity_err, addr_err, pkt_abort, busy;
   logic [7:0]  byte_out;
   logic [5:0]  pkt_len;
   logic [15:0] pkt_count;

   always #5 clock = ~clock;

   router_pkt_reader #(.PORT_ID(2'd0), .CNT_W(16)) dut (
      .clock(clock), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
      .soft_reset(soft_reset), .sink_ready(sink_ready), .read_enb(read_enb),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_last(byte_last),
      .pkt_done(pkt_done), .pkt_len(pkt_len), .parity_err(parity_err),
      .addr_err(addr_err), .pkt_abort(pkt_abort), .busy(busy), .pkt_count(pkt_count)
   );

   // FIFO model: data appears the cycle after read_enb
   logic [7:0] mem [0:255];
   logic [7:0] wr_ptr = 8'd0, rd_ptr;
   logic       vld_en = 1'b1, flush = 1'b0;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rd_ptr   <= 8'd0;
         data_out <= 8'd0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
      end else if (read_enb && rd_ptr != wr_ptr) begin
         data_out <= mem[rd_ptr];
         rd_ptr   <= rd_ptr + 8'd1;
      end
   end
   assign vld_out = vld_en && (rd_ptr != wr_ptr);

   int total = 0, bad = 0;
   int last_lat;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   // Push one packet, run until pkt_done (bounded), check payload and status.
   task automatic pkt(input string tag, input logic [7:0] hdr, input logic [63:0] pay,
                      input logic [7:0] par, input bit gap, input int exp_len,
                      input bit exp_perr, input bit exp_aerr);
      int nb, dc, fr;
      logic [7:0] gb [0:63];
      logic       gl [0:63];
      push(hdr);
      for (int i = 0; i < int'(hdr[7:2]); i++) push(pay[8*i +: 8]);
      push(par);
      nb = 0; dc = -1; fr = -1;
      for (int c = 0; c < 200; c++) begin
         if (gap) vld_en = (c % 3 != 2);
         #1;
         if (fr < 0 && read_enb) fr = c;
         if (byte_valid && nb < 64) begin
            gb[nb] = byte_out; gl[nb] = byte_last; nb++;
         end
         if (pkt_done) begin
            dc = c;
            chk({tag, "_len"},  pkt_len, exp_len);
            chk({tag, "_perr"}, parity_err, exp_perr);
            chk({tag, "_aerr"}, addr_err, exp_aerr);
         end
         @(negedge clock);
         if (dc >= 0) break;
      end
      vld_en = 1'b1;
      chk({tag, "_done"}, dc >= 0, 1);
      chk({tag, "_nbytes"}, nb, exp_len);
      for (int i = 0; i < exp_len && i < nb; i++) begin
         chk({tag, "_byte"}, gb[i], pay[8*i +: 8]);
         chk({tag, "_last"}, gl[i], i == exp_len - 1);
      end
      last_lat = dc - fr;
   endtask

   initial begin : main
      logic [8:0] e_re, e_bv, e_bl, e_dn, e_bz;
      logic [7:0] e_by [0:8];
      int nb, seen;

      resetn = 1'b0; soft_reset = 1'b0; sink_ready = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_read_enb", read_enb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_abort", pkt_abort, 0);
      chk("rst_bv", byte_valid, 0);
      chk("rst_count", pkt_count, 0);
      chk("rst_len", pkt_len, 0);
      chk("rst_errs", {parity_err, addr_err}, 0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);

      // Test 1: cycle-accurate walk of 0C,11,22,33,0C
      e_re = 9'b000111101; e_bv = 9'b000111000; e_bl = 9'b000100000;
      e_dn = 9'b010000000; e_bz = 9'b011111110;
      e_by[3] = 8'h11; e_by[4] = 8'h22; e_by[5] = 8'h33;
      push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
      for (int c = 0; c < 9; c++) begin
         #1;
         chk($sformatf("t1_re_c%0d", c), read_enb, e_re[c]);
         chk($sformatf("t1_bv_c%0d", c), byte_valid, e_bv[c]);
         chk($sformatf("t1_bl_c%0d", c), byte_last, e_bl[c]);
         chk($sformatf("t1_done_c%0d", c), pkt_done, e_dn[c]);
         chk($sformatf("t1_busy_c%0d", c), busy, e_bz[c]);
         if (e_bv[c]) chk($sformatf("t1_byte_c%0d", c), byte_out, e_by[c]);
         if (e_dn[c]) begin
            chk("t1_len", pkt_len, 3);
            chk("t1_errs", {parity_err, addr_err}, 0);
         end
         @(negedge clock);
      end
      #1 chk("t1_count", pkt_count, 1);
      @(negedge clock);

      // Test 2: bad parity, then a good packet right behind it
      pkt("t2a", 8'h0C, 64'h332211, 8'h0D, 1'b0, 3, 1'b1, 1'b0);
      #1 chk("t2a_count", pkt_count, 1);
      @(negedge clock);
      pkt("t2b", 8'h0C, 64'h332211, 8'h0C, 1'b0, 3, 1'b0, 1'b0);
      #1 chk("t2b_count", pkt_count, 2);
      @(negedge clock);

      // Test 3: wrong address still fully drained
      pkt("t3", 8'h0D, 64'h332211, 8'h0D, 1'b0, 3, 1'b0, 1'b1);
      #1 chk("t3_count", pkt_count, 2);
      @(negedge clock);

      // Test 4: zero-length packet, done 4 cycles after header read
      pkt("t4", 8'h00, 64'h0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
      chk("t4_lat", last_lat, 4);
      #1 chk("t4_count", pkt_count, 3);
      @(negedge clock);

      // Test 5: sink_ready low cycles 3..12 after the first payload read
      push(8'h10); push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4); push(8'h14);
      nb = 0; seen = 0;
      for (int c = 0; c < 60; c++) begin
         sink_ready = !(c >= 3 && c <= 12);
         #1;
         if (c >= 3 && c <= 12) chk($sformatf("t5_stall_re_c%0d", c), read_enb, 0);
         if (byte_valid) begin
            if (c >= 3 && c <= 12) seen++;
            case (nb)
               0: chk("t5_b0", byte_out, 8'hA1);
               1: chk("t5_b1", byte_out, 8'hB2);
               2: chk("t5_b2", byte_out, 8'hC3);
               default: chk("t5_b3", byte_out, 8'hD4);
            endcase
            nb++;
         end
         if (pkt_done) begin
            chk("t5_len", pkt_len, 4);
            chk("t5_errs", {parity_err, addr_err}, 0);
            @(negedge clock);
            break;
         end
         @(negedge clock);
      end
      sink_ready = 1'b1;
      chk("t5_inflight", seen, 1);
      chk("t5_nbytes", nb, 4);
      #1 chk("t5_count", pkt_count, 4);
      @(negedge clock);
      pkt("t5gap", 8'h10, 64'hD4C3B2A1, 8'h14, 1'b1, 4, 1'b0, 1'b0);
      #1 chk("t5gap_count", pkt_count, 5);
      @(negedge clock);

      // Test 6: soft_reset mid-packet while backpressured
      push(8'h0C); push(8'h11); push(8'h22); push(8'h33); push(8'h0C);
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (byte_valid) seen = 1;
         @(negedge clock);
         if (seen) break;
      end
      chk("t6_started", seen, 1);
      sink_ready = 1'b0;
      repeat (2) @(negedge clock);
      soft_reset = 1'b1; flush = 1'b1;
      #1;
      chk("t6_sr_re", read_enb, 0);
      chk("t6_sr_done", pkt_done, 0);
      @(negedge clock);
      soft_reset = 1'b0; flush = 1'b0;
      #1;
      chk("t6_abort", pkt_abort, 1);
      chk("t6_busy", busy, 0);
      chk("t6_done", pkt_done, 0);
      @(negedge clock);
      #1;
      chk("t6_abort_pulse", pkt_abort, 0);
      chk("t6_count", pkt_count, 5);
      @(negedge clock);
      soft_reset = 1'b1;
      @(negedge clock);
      soft_reset = 1'b0;
      #1 chk("t6_idle_sr_abort", pkt_abort, 0);
      @(negedge clock);
      sink_ready = 1'b1;
      pkt("t6fresh", 8'h08, 64'hA2AA, 8'h00, 1'b0, 2, 1'b0, 1'b0);
      #1 chk("t6fresh_count", pkt_count, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
